// File: rtl/sec32_encode_stage.sv
// SEC32 check-bit encoder feeding a 2-entry output FIFO, plus a saturating delivered-word counter.
// Optional one-shot codeword bit-flip injection is enabled by defining SEC_ERRINJ_EN.
module sec32_encode_stage #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [7:0]       out_check,
   output logic             out_en,
   input  logic             inj_req,
   input  logic [5:0]       inj_bit,
   output logic [CNT_W-1:0] sent_cnt
);

   // Column for d[i]: one-hot on i[4:3] in c[3:0], {~^p, p} with p = i[2:0] in c[7:4].
   function automatic logic [7:0] sec32_check(input logic [31:0] d);
      logic [7:0] c;
      logic [4:0] idx;
      c = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         idx = i[4:0];
         c[{1'b0, idx[4:3]}] ^= d[idx];
         c[4] ^= d[idx] & idx[0];
         c[5] ^= d[idx] & idx[1];
         c[6] ^= d[idx] & idx[2];
         c[7] ^= d[idx] & ~(^idx[2:0]);
      end
      return c;
   endfunction

   logic [39:0]      mem_q [2];
   logic [1:0]       count_q, count_d;
   logic             wr_ptr_q, rd_ptr_q;
   logic             rdy_q;
   logic [CNT_W-1:0] sent_q, sent_d;
   logic             push, pop;
   logic [39:0]      cw_in;
   logic [39:0]      flip_mask;

   // rdy_q keeps in_ready low while reset is asserted and rises on the first edge after release.
   assign in_ready  = rdy_q & (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign out_en    = out_valid;
   assign out_data  = mem_q[rd_ptr_q][31:0];
   assign out_check = mem_q[rd_ptr_q][39:32];
   assign sent_cnt  = sent_q;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      cw_in = {sec32_check(in_data), in_data} ^ flip_mask;
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end
      sent_d = sent_q;
      if (pop && (sent_q != '1)) begin
         sent_d = sent_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         count_q  <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         rdy_q    <= 1'b0;
         sent_q   <= '0;
      end else begin
         rdy_q   <= 1'b1;
         count_q <= count_d;
         sent_q  <= sent_d;
         if (push) begin
            mem_q[wr_ptr_q] <= cw_in;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

`ifdef SEC_ERRINJ_EN
   logic       arm_q, arm_eff;
   logic [5:0] arm_bit_q, arm_bit_eff;

   // A same-cycle request applies to a same-cycle accept; out-of-range bits arm nothing.
   always_comb begin
      arm_eff     = arm_q;
      arm_bit_eff = arm_bit_q;
      if (inj_req && (inj_bit < 6'd40)) begin
         arm_eff     = 1'b1;
         arm_bit_eff = inj_bit;
      end
      flip_mask = arm_eff ? (40'd1 << arm_bit_eff) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_q     <= 1'b0;
         arm_bit_q <= '0;
      end else begin
         arm_q     <= arm_eff & ~push;
         arm_bit_q <= arm_bit_eff;
      end
   end
`else
   logic unused_inj;
   always_comb begin
      unused_inj = ^{inj_req, inj_bit};
      flip_mask  = '0;
   end
`endif

endmodule

// File: tb/tb_sec32_encode_stage.sv
// Directed self-checking bench for sec32_encode_stage: encoding, backpressure, random-gap
// ordering, counter saturation (CNT_W=4 instance), reset behaviour and optional injection.
module tb_sec32_encode_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [7:0]  out_check;
   logic        out_en;
   logic        inj_req = 1'b0;
   logic [5:0]  inj_bit = '0;
   logic [15:0] sent_cnt;

   logic        s_in_valid = 1'b0;
   logic        s_in_ready;
   logic [31:0] s_in_data = '0;
   logic        s_out_valid;
   logic        s_out_ready = 1'b0;
   logic [31:0] s_out_data;
   logic [7:0]  s_out_check;
   logic        s_out_en;
   logic [3:0]  s_sent_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sec32_encode_stage dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_check(out_check), .out_en(out_en),
      .inj_req(inj_req), .inj_bit(inj_bit), .sent_cnt(sent_cnt)
   );

   sec32_encode_stage #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .out_check(s_out_check), .out_en(s_out_en),
      .inj_req(1'b0), .inj_bit(6'd0), .sent_cnt(s_sent_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference check bits from the H-matrix column table.
   function automatic logic [7:0] ref_chk(input logic [31:0] d);
      logic [3:0] hi [8] = '{4'h8, 4'h1, 4'h2, 4'hB, 4'h4, 4'hD, 4'hE, 4'h7};
      logic [7:0] c;
      logic [4:0] idx;
      c = '0;
      for (int i = 0; i < 32; i++) begin
         idx = i[4:0];
         if (d[idx]) c ^= {hi[idx[2:0]], 4'b0001 << idx[4:3]};
      end
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      inj_req   = 1'b0;
      rst_n     = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_release_in_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] enc_d [4] = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [7:0]  enc_c [4] = '{8'h00, 8'h81, 8'h78, 8'h00};
      logic [31:0] q [$];
      int          mcnt, acc, sent;
      bit          do_push, do_pop;

      // Reset state
      #3;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_en", 64'(out_en), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_check", 64'(out_check), 64'd0);
      chk("rst_sent_cnt", 64'(sent_cnt), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("first_edge_in_ready", 64'(in_ready), 64'd1);

      // Counter saturation on the CNT_W=4 instance: 20 transfers
      s_out_ready = 1'b1;
      s_in_valid  = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         s_in_data = 32'(k);
         tick();
         if (k == 10) chk("sat_mid_cnt", 64'(s_sent_cnt), 64'd9);
      end
      s_in_valid = 1'b0;
      repeat (2) tick();
      chk("sat_cnt_hold", 64'(s_sent_cnt), 64'd15);

      // Encoding spot checks with out_ready=1
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = enc_d[i];
         tick();
         in_valid = 1'b0;
         chk("enc_valid", 64'(out_valid), 64'd1);
         chk("enc_en", 64'(out_en), 64'd1);
         chk("enc_data", 64'(out_data), 64'(enc_d[i]));
         chk("enc_check", 64'(out_check), 64'(enc_c[i]));
         tick();
         chk("enc_drain", 64'(out_valid), 64'd0);
      end

      // Backpressure
      do_reset();
      in_valid = 1'b1;
      in_data  = 32'h1;
      tick();
      chk("bp_ready_after1", 64'(in_ready), 64'd1);
      in_data = 32'h2;
      tick();
      chk("bp_ready_after2", 64'(in_ready), 64'd0);
      in_data = 32'h3;
      tick();
      chk("bp_ready_held", 64'(in_ready), 64'd0);
      chk("bp_head_stable", 64'(out_data), 64'h1);
      out_ready = 1'b1;
      tick();
      chk("bp_ready_after_pop", 64'(in_ready), 64'd1);
      chk("bp_head2", 64'(out_data), 64'h2);
      tick();
      in_valid = 1'b0;
      chk("bp_pushpop_valid", 64'(out_valid), 64'd1);
      chk("bp_pushpop_ready", 64'(in_ready), 64'd1);
      chk("bp_head3", 64'(out_data), 64'h3);
      chk("bp_head3_check", 64'(out_check), 64'(ref_chk(32'h3)));
      tick();
      chk("bp_empty", 64'(out_valid), 64'd0);
      chk("bp_sent_cnt", 64'(sent_cnt), 64'd3);

      // Random-gap ordering against a queue model
      do_reset();
      mcnt = 0;
      acc  = 0;
      sent = 0;
      for (int cyc = 0; cyc < 3000 && sent < 100; cyc++) begin
         chk("rnd_in_ready", 64'(in_ready), 64'(mcnt != 2));
         chk("rnd_out_valid", 64'(out_valid), 64'(mcnt != 0));
         in_valid  = (acc < 100) && ($urandom_range(0, 2) != 0);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 2) != 0);
         do_push   = in_valid && (mcnt != 2);
         do_pop    = out_ready && (mcnt != 0);
         if (do_pop) begin
            chk("rnd_data", 64'(out_data), 64'(q[0]));
            chk("rnd_check", 64'(out_check), 64'(ref_chk(q[0])));
            void'(q.pop_front());
            sent++;
         end
         if (do_push) begin
            q.push_back(in_data);
            acc++;
         end
         mcnt = mcnt + int'(do_push) - int'(do_pop);
         tick();
      end
      in_valid = 1'b0;
      chk("rnd_delivered", 64'(sent), 64'd100);
      chk("rnd_sent_cnt", 64'(sent_cnt), 64'd100);

`ifdef SEC_ERRINJ_EN
      // Injection: check bit 3, then data bit 0 armed a cycle ahead, then clean
      do_reset();
      out_ready = 1'b1;
      inj_req   = 1'b1;
      inj_bit   = 6'd35;
      in_valid  = 1'b1;
      in_data   = 32'h0;
      tick();
      inj_req  = 1'b0;
      in_valid = 1'b0;
      chk("inj35_data", 64'(out_data), 64'h0);
      chk("inj35_check", 64'(out_check), 64'h08);
      inj_req = 1'b1;
      inj_bit = 6'd0;
      tick();
      inj_req  = 1'b0;
      in_valid = 1'b1;
      tick();
      chk("inj0_data", 64'(out_data), 64'h1);
      chk("inj0_check", 64'(out_check), 64'h00);
      tick();
      in_valid = 1'b0;
      chk("inj_clean_data", 64'(out_data), 64'h0);
      chk("inj_clean_check", 64'(out_check), 64'h00);
      tick();
`endif

      // Reset with two words buffered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hAAAA_5555;
      tick();
      in_data = 32'h1234_5678;
      tick();
      in_valid = 1'b0;
      chk("mid_full", 64'(in_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_out_en", 64'(out_en), 64'd0);
      chk("mid_rst_out_data", 64'(out_data), 64'd0);
      chk("mid_rst_out_check", 64'(out_check), 64'd0);
      chk("mid_rst_sent_cnt", 64'(sent_cnt), 64'd0);
      repeat (2) tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      for (int k = 0; k < 3; k++) begin
         chk("post_rst_no_stale", 64'(out_valid), 64'd0);
         tick();
      end
      chk("post_rst_sent_cnt", 64'(sent_cnt), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
